// File: rtl/sprite_rom_arbiter_if.sv
// ============================================================================
// Module   : sprite_rom_arbiter_if
// Brief    : Bus to the shared 16x16 sprite ROM (address, image select, data).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sprite_rom_arbiter_if;
  logic [7:0]  rom_addr;
  logic        rom_switch;
  logic [23:0] rom_rgb;

  modport master (
    output rom_addr,
    output rom_switch,
    input  rom_rgb
  );

  modport slave (
    input  rom_addr,
    input  rom_switch,
    output rom_rgb
  );
endinterface

`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
// ============================================================================
// Module   : sprite_rom_arbiter
// Brief    : Time-shares one sprite ROM between player and enemy sprites and
//            resolves the visible colour for each strobed pixel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_rom_arbiter #(
  parameter logic [23:0] KEY_RGB = 24'hFFD700
) (
  input  wire logic                 Clk,
  input  wire logic                 Reset,
  input  wire logic                 pix_en,
  input  wire logic                 vs,
  input  wire logic [9:0]           DrawX,
  input  wire logic [9:0]           DrawY,
  input  wire logic [9:0]           PlayerX,
  input  wire logic [9:0]           PlayerY,
  input  wire logic [9:0]           EnemyX,
  input  wire logic [9:0]           EnemyY,
  input  wire logic                 facing_left,
  input  wire logic                 enemy_en,
  sprite_rom_arbiter_if.master      rom,
  output logic [23:0]               pixel_rgb,
  output logic                      pixel_on,
  output logic [1:0]                pixel_src,
  output logic                      overrun
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH_P = 2'd1,
    S_FETCH_E = 2'd2
  } state_t;

  localparam logic [1:0]  c_SRC_NONE   = 2'b00;
  localparam logic [1:0]  c_SRC_PLAYER = 2'b01;
  localparam logic [1:0]  c_SRC_ENEMY  = 2'b10;
  localparam logic [10:0] c_SPR_SIZE   = 11'd16;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_vs_q;
  logic        w_vs_rise;

  logic [9:0]  r_player_x;
  logic [9:0]  r_player_y;
  logic [9:0]  r_enemy_x;
  logic [9:0]  r_enemy_y;
  logic        r_facing_left;
  logic        r_enemy_en;

  logic        w_accept;
  logic        w_p_hit;
  logic        w_e_hit;
  logic [3:0]  w_p_row;
  logic [3:0]  w_p_col;
  logic [3:0]  w_p_col_eff;
  logic [3:0]  w_e_row;
  logic [3:0]  w_e_col;

  logic        r_p_hit;
  logic        r_e_hit;
  logic [7:0]  r_p_addr;
  logic [7:0]  r_e_addr;
  logic [23:0] r_rgb_p;

  // Zero-extended compare keeps sprites near the right edge from wrapping to column 0.
  function automatic logic in_span(input logic [9:0] pos, input logic [9:0] org);
    logic [10:0] p;
    logic [10:0] o;
    p = {1'b0, pos};
    o = {1'b0, org};
    return (p >= o) && (p < (o + c_SPR_SIZE));
  endfunction

  assign w_vs_rise = vs & ~r_vs_q;
  assign w_accept  = pix_en && ((r_state == S_IDLE) || (r_state == S_FETCH_E));

  assign w_p_hit = in_span(DrawX, r_player_x) && in_span(DrawY, r_player_y);
  assign w_e_hit = r_enemy_en && in_span(DrawX, r_enemy_x) && in_span(DrawY, r_enemy_y);

  assign w_p_row     = DrawY[3:0] - r_player_y[3:0];
  assign w_p_col     = DrawX[3:0] - r_player_x[3:0];
  assign w_p_col_eff = r_facing_left ? w_p_col : ~w_p_col;
  assign w_e_row     = DrawY[3:0] - r_enemy_y[3:0];
  assign w_e_col     = DrawX[3:0] - r_enemy_x[3:0];

  // Frame-stable copies of the sprite placement.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_vs_q        <= 1'b0;
      r_player_x    <= '0;
      r_player_y    <= '0;
      r_enemy_x     <= '0;
      r_enemy_y     <= '0;
      r_facing_left <= 1'b0;
      r_enemy_en    <= 1'b0;
    end else begin
      r_vs_q <= vs;
      if (w_vs_rise) begin
        r_player_x    <= PlayerX;
        r_player_y    <= PlayerY;
        r_enemy_x     <= EnemyX;
        r_enemy_y     <= EnemyY;
        r_facing_left <= facing_left;
        r_enemy_en    <= enemy_en;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    rom.rom_addr   = 8'd0;
    rom.rom_switch = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pix_en) begin
          w_state_nxt = S_FETCH_P;
        end
      end
      S_FETCH_P: begin
        rom.rom_addr   = r_p_addr;
        rom.rom_switch = 1'b1;
        w_state_nxt    = S_FETCH_E;
      end
      S_FETCH_E: begin
        rom.rom_addr   = r_e_addr;
        rom.rom_switch = 1'b0;
        w_state_nxt    = pix_en ? S_FETCH_P : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Per-pixel fetch context, captured when a strobe is accepted.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_p_hit  <= 1'b0;
      r_e_hit  <= 1'b0;
      r_p_addr <= 8'd0;
      r_e_addr <= 8'd0;
      r_rgb_p  <= 24'd0;
    end else begin
      if (w_accept) begin
        r_p_hit  <= w_p_hit;
        r_e_hit  <= w_e_hit;
        r_p_addr <= {w_p_row, w_p_col_eff};
        r_e_addr <= {w_e_row, w_e_col};
      end
      if (r_state == S_FETCH_P) begin
        r_rgb_p <= rom.rom_rgb;
      end
    end
  end

  // The enemy word is on the ROM bus during FETCH_E, so both colours meet here.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pixel_rgb <= 24'd0;
      pixel_on  <= 1'b0;
      pixel_src <= c_SRC_NONE;
    end else if (r_state == S_FETCH_E) begin
      if (r_p_hit && (r_rgb_p != KEY_RGB)) begin
        pixel_rgb <= r_rgb_p;
        pixel_on  <= 1'b1;
        pixel_src <= c_SRC_PLAYER;
      end else if (r_e_hit && (rom.rom_rgb != KEY_RGB)) begin
        pixel_rgb <= rom.rom_rgb;
        pixel_on  <= 1'b1;
        pixel_src <= c_SRC_ENEMY;
      end else begin
        pixel_rgb <= 24'd0;
        pixel_on  <= 1'b0;
        pixel_src <= c_SRC_NONE;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      overrun <= 1'b0;
    end else if (pix_en && (r_state == S_FETCH_P)) begin
      overrun <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
// ============================================================================
// Module   : tb_sprite_rom_arbiter
// Brief    : Directed and randomized checks of sprite_rom_arbiter against a
//            behavioural sprite-compositing model and an array-based ROM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_rom_arbiter;

  localparam logic [23:0] c_KEY = 24'hFFD700;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic        vs = 1'b0;
  logic [9:0]  draw_x = '0;
  logic [9:0]  draw_y = '0;
  logic [9:0]  player_x = '0;
  logic [9:0]  player_y = '0;
  logic [9:0]  enemy_x = '0;
  logic [9:0]  enemy_y = '0;
  logic        facing_left = 1'b0;
  logic        enemy_en = 1'b0;
  logic [23:0] pixel_rgb;
  logic        pixel_on;
  logic [1:0]  pixel_src;
  logic        overrun;

  logic [23:0] rom_p [256];
  logic [23:0] rom_e [256];

  int total = 0;
  int bad   = 0;

  // Model of what the block latched at the last frame edge.
  int m_px = 0, m_py = 0, m_ex = 0, m_ey = 0;
  bit m_fl = 0, m_en = 0;

  sprite_rom_arbiter_if rom_bus ();

  assign rom_bus.rom_rgb = rom_bus.rom_switch ? rom_p[rom_bus.rom_addr] : rom_e[rom_bus.rom_addr];

  sprite_rom_arbiter #(.KEY_RGB(c_KEY)) dut (
    .Clk         (clk),
    .Reset       (rst),
    .pix_en      (pix_en),
    .vs          (vs),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .PlayerX     (player_x),
    .PlayerY     (player_y),
    .EnemyX      (enemy_x),
    .EnemyY      (enemy_y),
    .facing_left (facing_left),
    .enemy_en    (enemy_en),
    .rom         (rom_bus.master),
    .pixel_rgb   (pixel_rgb),
    .pixel_on    (pixel_on),
    .pixel_src   (pixel_src),
    .overrun     (overrun)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected pixel for a draw position, straight from the compositing rules.
  task automatic model(input int dx, input int dy,
                       output logic [23:0] rgb, output logic on, output logic [1:0] src,
                       output bit ph, output bit eh, output logic [7:0] pa, output logic [7:0] ea);
    int pcol, prow, ecol, erow;
    ph = (dx >= m_px) && (dx < m_px + 16) && (dy >= m_py) && (dy < m_py + 16);
    eh = m_en && (dx >= m_ex) && (dx < m_ex + 16) && (dy >= m_ey) && (dy < m_ey + 16);
    pcol = dx - m_px;
    prow = dy - m_py;
    if (!m_fl) pcol = 15 - pcol;
    ecol = dx - m_ex;
    erow = dy - m_ey;
    pa = ph ? 8'(prow * 16 + pcol) : 8'd0;
    ea = eh ? 8'(erow * 16 + ecol) : 8'd0;
    if (ph && rom_p[pa] != c_KEY) begin
      rgb = rom_p[pa]; on = 1'b1; src = 2'b01;
    end else if (eh && rom_e[ea] != c_KEY) begin
      rgb = rom_e[ea]; on = 1'b1; src = 2'b10;
    end else begin
      rgb = 24'd0; on = 1'b0; src = 2'b00;
    end
  endtask

  task automatic new_frame(input int px, input int py, input int ex, input int ey,
                           input bit fl, input bit en);
    @(negedge clk);
    player_x = 10'(px); player_y = 10'(py);
    enemy_x  = 10'(ex); enemy_y  = 10'(ey);
    facing_left = fl; enemy_en = en;
    vs = 1'b1;
    @(negedge clk);
    vs = 1'b0;
    @(negedge clk);
    m_px = px; m_py = py; m_ex = ex; m_ey = ey; m_fl = fl; m_en = en;
  endtask

  // One isolated pixel: strobe, check both fetches, then the resolved result.
  task automatic run_pixel(input string tag, input int dx, input int dy,
                           output logic [23:0] o_rgb, output logic o_on,
                           output logic [1:0] o_src, output logic [7:0] o_pa);
    logic [23:0] e_rgb; logic e_on; logic [1:0] e_src; bit ph, eh; logic [7:0] pa, ea;
    @(negedge clk);
    draw_x = 10'(dx); draw_y = 10'(dy); pix_en = 1'b1;
    model(dx, dy, e_rgb, e_on, e_src, ph, eh, pa, ea);
    @(negedge clk);
    pix_en = 1'b0;
    chk({tag, "_swp"}, 32'(rom_bus.rom_switch), 32'd1);
    o_pa = rom_bus.rom_addr;
    if (ph) chk({tag, "_paddr"}, 32'(rom_bus.rom_addr), 32'(pa));
    @(negedge clk);
    chk({tag, "_swe"}, 32'(rom_bus.rom_switch), 32'd0);
    if (eh) chk({tag, "_eaddr"}, 32'(rom_bus.rom_addr), 32'(ea));
    @(negedge clk);
    o_rgb = pixel_rgb; o_on = pixel_on; o_src = pixel_src;
    chk({tag, "_rgb"}, 32'(pixel_rgb), 32'(e_rgb));
    chk({tag, "_on"},  32'(pixel_on),  32'(e_on));
    chk({tag, "_src"}, 32'(pixel_src), 32'(e_src));
  endtask

  initial begin
    logic [23:0] o_rgb; logic o_on; logic [1:0] o_src; logic [7:0] o_pa;
    logic [23:0] q_rgb [$]; logic q_on [$]; logic [1:0] q_src [$];
    logic [23:0] e_rgb; logic e_on; logic [1:0] e_src; bit ph, eh; logic [7:0] pa, ea;

    for (int i = 0; i < 256; i++) begin
      rom_p[i] = ($urandom_range(0, 3) == 0) ? c_KEY : 24'($urandom);
      rom_e[i] = ($urandom_range(0, 3) == 0) ? c_KEY : 24'($urandom);
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_on",   32'(pixel_on),   32'd0);
    chk("rst_rgb",  32'(pixel_rgb),  32'd0);
    chk("rst_src",  32'(pixel_src),  32'd0);
    chk("rst_ovr",  32'(overrun),    32'd0);
    chk("rst_addr", 32'(rom_bus.rom_addr),   32'd0);
    chk("rst_sw",   32'(rom_bus.rom_switch), 32'd0);

    // Player at (100,50), art used unmirrored.
    rom_p[8'h00] = 24'hFF0000;
    new_frame(100, 50, 600, 400, 1'b1, 1'b0);
    run_pixel("p_left", 100, 50, o_rgb, o_on, o_src, o_pa);
    chk("p_left_addr00", 32'(o_pa),  32'h00);
    chk("p_left_red",    32'(o_rgb), 32'hFF0000);
    chk("p_left_src",    32'(o_src), 32'd1);

    rom_p[8'h0F] = 24'h00FF00;
    new_frame(100, 50, 600, 400, 1'b0, 1'b0);
    run_pixel("p_right", 100, 50, o_rgb, o_on, o_src, o_pa);
    chk("p_right_addr0F", 32'(o_pa), 32'h0F);

    // Transparent player pixel lets the enemy through.
    rom_p[8'h00] = c_KEY;
    rom_e[8'h00] = 24'h3F51B5;
    new_frame(200, 200, 200, 200, 1'b1, 1'b1);
    run_pixel("overlap", 200, 200, o_rgb, o_on, o_src, o_pa);
    chk("overlap_rgb", 32'(o_rgb), 32'h3F51B5);
    chk("overlap_src", 32'(o_src), 32'd2);

    new_frame(500, 300, 200, 200, 1'b1, 1'b0);
    run_pixel("en_off", 200, 200, o_rgb, o_on, o_src, o_pa);
    chk("en_off_on",  32'(o_on),  32'd0);
    chk("en_off_src", 32'(o_src), 32'd0);

    // Right-edge sprite: no wraparound to low columns.
    rom_p[8'h08] = 24'h123456;
    new_frame(1015, 0, 0, 400, 1'b1, 1'b0);
    run_pixel("edge_hit", 1023, 0, o_rgb, o_on, o_src, o_pa);
    chk("edge_hit_addr", 32'(o_pa), 32'h08);
    chk("edge_hit_on",   32'(o_on), 32'd1);
    run_pixel("edge_wrap", 5, 0, o_rgb, o_on, o_src, o_pa);
    chk("edge_wrap_on",  32'(o_on), 32'd0);

    // Mid-frame position change must be ignored until the next frame edge.
    rom_p[8'h33] = 24'hABCDEF;
    new_frame(300, 100, 0, 400, 1'b1, 1'b0);
    @(negedge clk);
    player_x = 10'd700;
    run_pixel("midframe_old", 303, 103, o_rgb, o_on, o_src, o_pa);
    chk("midframe_old_on", 32'(o_on), 32'd1);
    run_pixel("midframe_new", 703, 103, o_rgb, o_on, o_src, o_pa);
    chk("midframe_new_on", 32'(o_on), 32'd0);
    new_frame(700, 100, 0, 400, 1'b1, 1'b0);
    run_pixel("nextframe", 703, 103, o_rgb, o_on, o_src, o_pa);
    chk("nextframe_on", 32'(o_on), 32'd1);

    // Randomized back-to-back strobes, one every two cycles.
    for (int f = 0; f < 4; f++) begin
      int px, py, ex, ey;
      px = $urandom_range(0, 1023); py = $urandom_range(0, 520);
      ex = $urandom_range(0, 1023); ey = $urandom_range(0, 520);
      if (f == 0) begin ex = px + 6; ey = py + 4; end
      new_frame(px, py, ex, ey, 1'($urandom), (f == 0) ? 1'b1 : 1'($urandom));
      for (int k = 0; k <= 40; k++) begin
        int dx, dy, sel;
        @(negedge clk);
        if (k > 0) begin
          chk("strm_swe", 32'(rom_bus.rom_switch), 32'd0);
        end
        if (k < 40) begin
          sel = $urandom_range(0, 2);
          if (sel == 0) begin
            dx = (m_px + $urandom_range(0, 19) - 2) & 1023;
            dy = (m_py + $urandom_range(0, 19) - 2) & 1023;
          end else if (sel == 1) begin
            dx = (m_ex + $urandom_range(0, 19) - 2) & 1023;
            dy = (m_ey + $urandom_range(0, 19) - 2) & 1023;
          end else begin
            dx = $urandom_range(0, 1023); dy = $urandom_range(0, 1023);
          end
          draw_x = 10'(dx); draw_y = 10'(dy); pix_en = 1'b1;
          model(dx, dy, e_rgb, e_on, e_src, ph, eh, pa, ea);
          q_rgb.push_back(e_rgb); q_on.push_back(e_on); q_src.push_back(e_src);
        end else begin
          pix_en = 1'b0;
        end
        @(negedge clk);
        pix_en = 1'b0;
        if (k < 40) begin
          chk("strm_swp", 32'(rom_bus.rom_switch), 32'd1);
          if (ph) chk("strm_paddr", 32'(rom_bus.rom_addr), 32'(pa));
        end
        if (k > 0) begin
          chk("strm_rgb", 32'(pixel_rgb), 32'(q_rgb.pop_front()));
          chk("strm_on",  32'(pixel_on),  32'(q_on.pop_front()));
          chk("strm_src", 32'(pixel_src), 32'(q_src.pop_front()));
        end
      end
    end
    chk("strm_no_ovr", 32'(overrun), 32'd0);

    // Strobe on consecutive cycles: second one dropped, overrun sticks.
    rom_p[8'h11] = 24'h0A0B0C;
    rom_p[8'h55] = 24'h0D0E0F;
    new_frame(400, 400, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    draw_x = 10'd401; draw_y = 10'd401; pix_en = 1'b1;
    @(negedge clk);
    draw_x = 10'd405; draw_y = 10'd405;
    @(negedge clk);
    pix_en = 1'b0;
    @(negedge clk);
    chk("ovr_rgb",  32'(pixel_rgb), 32'h0A0B0C);
    chk("ovr_flag", 32'(overrun),   32'd1);
    repeat (4) @(negedge clk);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-fetch drops the pixel and clears the frame latches.
    @(negedge clk);
    draw_x = 10'd401; draw_y = 10'd401; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_px = 0; m_py = 0; m_ex = 0; m_ey = 0; m_fl = 0; m_en = 0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_on",  32'(pixel_on),  32'd0);
      chk("rst_mid_rgb", 32'(pixel_rgb), 32'd0);
      chk("rst_mid_ovr", 32'(overrun),   32'd0);
      chk("rst_mid_sw",  32'(rom_bus.rom_switch), 32'd0);
    end
    rom_p[8'h2C] = 24'h777777;
    run_pixel("post_rst", 3, 2, o_rgb, o_on, o_src, o_pa);
    chk("post_rst_addr", 32'(o_pa),  32'h2C);
    chk("post_rst_rgb",  32'(o_rgb), 32'h777777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
